escaner_teclado: RTL
====================

ESCANER_TECLADO -- requirements
Module: escaner_teclado

Interface
REQ-001 Parameter SCAN_DIV, default 8: SHALL set the clock cycles each column is driven while scanning.
REQ-002 Parameter DEBOUNCE_CICLOS, default 4: SHALL set the consecutive stable samples required on press and on release.
REQ-003 Parameter REPETIR_CICLOS, default 64: SHALL set the auto-repeat period; used only under REQ-020.
REQ-004 CLK  in  1  SHALL be the single clock; all logic is on its rising edge.
REQ-005 RESET  in  1  SHALL be a synchronous, active-low reset.
REQ-006 FILAS  in  4  SHALL carry the keypad row sense lines, high = key closed in the driven column.
REQ-007 COLUMNAS  out  4  SHALL be the one-hot column drive.
REQ-008 DIGITO  out  4  SHALL hold the last accepted digit, 0-9.
REQ-009 DIGITO_STB  out  1  SHALL be a 1-cycle pulse marking a new DIGITO; it feeds the cajero's DIGITO/DIGITO_STB inputs directly.
REQ-010 BORRAR_STB, ENTER_STB  out  1 each  SHALL be 1-cycle pulses for the '*' and '#' keys respectively.

Function
REQ-011 Key map, row r / column c, SHALL be:
- row 0: 1 2 3 A
- row 1: 4 5 6 B
- row 2: 7 8 9 C
- row 3: * 0 # D
- A-D SHALL be debounced but produce no strobe.
REQ-012 The FSM SHALL have exactly the states ESCANEO, REBOTE, PRESIONADA and LIBERACION.
REQ-013 ESCANEO:
- COLUMNAS rotates 0001->0010->0100->1000->0001, advancing every SCAN_DIV cycles.
- If FILAS has exactly one bit set, the FSM latches row and column, freezes COLUMNAS and goes to REBOTE.
- Zero bits or two or more bits set SHALL be ignored.
REQ-014 REBOTE:
- Each cycle where FILAS equals the latched one-hot row increments the counter.
- Any other value returns the FSM to ESCANEO, clears the counter and resumes rotation from the frozen column.
REQ-015 When the REBOTE count reaches DEBOUNCE_CICLOS (samples in cycles t0+1..t0+N, where t0 is the detect cycle), the block SHALL:
- drive the matching strobe high in cycle t0+N+1, for exactly 1 cycle;
- update DIGITO in that same cycle, for digits only;
- enter PRESIONADA.
REQ-016 PRESIONADA SHALL hold while FILAS is nonzero, and SHALL go to LIBERACION on the first cycle with FILAS==0.
REQ-017 LIBERACION:
- SHALL return to ESCANEO after DEBOUNCE_CICLOS consecutive cycles with FILAS==0.
- Any nonzero FILAS SHALL return it to PRESIONADA with the counter cleared.
- No strobe SHALL be issued on release.
REQ-018 At most one of DIGITO_STB, BORRAR_STB and ENTER_STB SHALL be high in any cycle; DIGITO SHALL be unchanged by non-digit keys.

Reset
REQ-019 While RESET==0 at a clock edge, the block SHALL on the next cycle present:
- state ESCANEO;
- COLUMNAS=0001;
- DIGITO=0;
- all strobes 0;
- all counters 0.
A reset in any state, including mid-debounce, SHALL discard the pending key with no strobe.

Configuration
REQ-020 With TECLADO_REPETICION_EN defined, holding a digit key in PRESIONADA SHALL re-issue DIGITO_STB with the same DIGITO every REPETIR_CICLOS cycles after the previous strobe.
- '*', '#' and A-D SHALL never repeat.
- Without the macro, the repeat counter SHALL be absent and each press SHALL yield exactly one strobe.

Structure
REQ-021 Package teclado_pkg SHALL hold:
- the FSM state enum;
- the 4x4 key-code map constant;
- key class codes (digit, borrar, enter, ignorada);
- the DIGITO width.
REQ-022 Sub-module contador_rebote SHALL implement the parameterised stable-sample counter (inputs: match, clear; output: done); the press and release phases SHALL share one instance.

Verification
REQ-023 Defaults, key '5' (row 1, column 1) held 30 cycles: exactly one DIGITO_STB, DIGITO=5, pulse width 1, and the strobe arrives 5 cycles after the detect cycle.
REQ-024 Key '8' closed for 2 cycles, open for 1, then held: the first closure yields no strobe; the FSM returns to ESCANEO; exactly one strobe with DIGITO=8 follows the stable hold.
REQ-025 With DIGITO=3 held from a prior press, '#' pressed: ENTER_STB high 1 cycle, DIGITO_STB stays 0, DIGITO stays 3; '*' likewise gives BORRAR_STB only.
REQ-026 FILAS=0011 (two rows at once) held 40 cycles: no strobe, and COLUMNAS keeps rotating.
REQ-027 Key '1' held, RESET=0 asserted 2 cycles after detect: no strobe, COLUMNAS=0001, DIGITO=0 on the next cycle.
REQ-028 TECLADO_REPETICION_EN defined, key '7' held 150 cycles past the first strobe: 3 strobes total, all DIGITO=7, spaced 64 cycles apart. Without the macro: exactly 1 strobe.

Source files
------------

// File: rtl/teclado_pkg.sv
// teclado_pkg: state, key map and key-class definitions shared by the keypad scanner.
package teclado_pkg;

   localparam int DIGITO_W = 4;

   typedef enum logic [1:0] {ESCANEO, REBOTE, PRESIONADA, LIBERACION} estado_t;

   typedef enum logic [1:0] {CLASE_DIGITO, CLASE_BORRAR, CLASE_ENTER, CLASE_IGNORADA} clase_t;

   localparam logic [3:0] COD_BORRAR = 4'hE;
   localparam logic [3:0] COD_ENTER  = 4'hF;

   // Indexed by {row, column}; '*' and '#' use codes above 9 so they never look like digits.
   localparam logic [3:0] MAPA_TECLAS [16] = '{
      4'h1,       4'h2, 4'h3,      4'hA,
      4'h4,       4'h5, 4'h6,      4'hB,
      4'h7,       4'h8, 4'h9,      4'hC,
      COD_BORRAR, 4'h0, COD_ENTER, 4'hD
   };

   function automatic clase_t clase_de(input logic [3:0] cod);
      return cod <= 4'd9 ? CLASE_DIGITO :
             cod == COD_BORRAR ? CLASE_BORRAR :
             cod == COD_ENTER ? CLASE_ENTER : CLASE_IGNORADA;
   endfunction

   function automatic logic [1:0] indice_fila(input logic [3:0] v);
      return v[3] ? 2'd3 : v[2] ? 2'd2 : v[1] ? 2'd1 : 2'd0;
   endfunction

endpackage

// File: rtl/contador_rebote.sv
// contador_rebote: counts consecutive matching samples; done fires on the N-th one.
module contador_rebote #(
   parameter int N = 4
) (
   input  logic CLK,
   input  logic RESET,
   input  logic match,
   input  logic clear,
   output logic done
);

   localparam int W = $clog2(N + 1);

   logic [W-1:0] cnt;

   assign done = match && !clear && cnt == W'(N - 1);

   always_ff @(posedge CLK) begin
      cnt <= (!RESET || clear || !match || done) ? '0 : cnt + 1'b1;
   end

endmodule

// File: rtl/escaner_teclado.sv
// escaner_teclado: 4x4 keypad scanner with press/release debounce and key strobes.
// Optional auto-repeat of held digit keys when TECLADO_REPETICION_EN is defined.
module escaner_teclado
   import teclado_pkg::*;
#(
   parameter int SCAN_DIV        = 8,
   parameter int DEBOUNCE_CICLOS = 4,
   parameter int REPETIR_CICLOS  = 64
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic [3:0]          FILAS,
   output logic [3:0]          COLUMNAS,
   output logic [DIGITO_W-1:0] DIGITO,
   output logic                DIGITO_STB,
   output logic                BORRAR_STB,
   output logic                ENTER_STB
);

   localparam int DW = $clog2(SCAN_DIV + 1);

   if (SCAN_DIV < 1 || DEBOUNCE_CICLOS < 1 || REPETIR_CICLOS < 1) begin : g_param_invalido
      $error("escaner_teclado: parameters must be >= 1");
   end

   estado_t             estado_q, estado_d;
   logic [1:0]          col_q, col_d, fila_q, fila_d;
   logic [DW-1:0]       div_q, div_d;
   logic [DIGITO_W-1:0] digito_d;
   logic                dig_stb_d, borrar_stb_d, enter_stb_d;
   logic                fila_uno, match, clear, done;
   logic [3:0]          fila_hot, codigo;
   clase_t              clase;

   assign COLUMNAS = 4'b0001 << col_q;
   assign fila_hot = 4'b0001 << fila_q;
   assign fila_uno = FILAS != 4'd0 && (FILAS & (FILAS - 4'd1)) == 4'd0;
   assign codigo   = MAPA_TECLAS[{fila_q, col_q}];
   assign clase    = clase_de(codigo);

   // One counter serves both phases: press looks for the latched row, release for all-open.
   assign match = estado_q == REBOTE ? FILAS == fila_hot : FILAS == 4'd0;
   assign clear = estado_q == ESCANEO || estado_q == PRESIONADA;

   contador_rebote #(.N(DEBOUNCE_CICLOS)) u_rebote (
      .CLK   (CLK),
      .RESET (RESET),
      .match (match),
      .clear (clear),
      .done  (done)
   );

`ifdef TECLADO_REPETICION_EN
   localparam int RW = $clog2(REPETIR_CICLOS + 1);
   logic [RW-1:0] rep_q, rep_d;
   always_ff @(posedge CLK) begin
      rep_q <= !RESET ? '0 : rep_d;
   end
`endif

   always_comb begin
      estado_d     = estado_q;
      col_d        = col_q;
      fila_d       = fila_q;
      div_d        = div_q;
      digito_d     = DIGITO;
      dig_stb_d    = 1'b0;
      borrar_stb_d = 1'b0;
      enter_stb_d  = 1'b0;
`ifdef TECLADO_REPETICION_EN
      rep_d        = '0;
`endif
      case (estado_q)
         ESCANEO: begin
            if (fila_uno) begin
               estado_d = REBOTE;
               fila_d   = indice_fila(FILAS);
               div_d    = '0;
            end else if (div_q == DW'(SCAN_DIV - 1)) begin
               div_d = '0;
               col_d = col_q + 2'd1;
            end else
               div_d = div_q + 1'b1;
         end
         REBOTE: begin
            if (!match)
               estado_d = ESCANEO;
            else if (done) begin
               estado_d     = PRESIONADA;
               dig_stb_d    = clase == CLASE_DIGITO;
               borrar_stb_d = clase == CLASE_BORRAR;
               enter_stb_d  = clase == CLASE_ENTER;
               digito_d     = clase == CLASE_DIGITO ? codigo : DIGITO;
            end
         end
         PRESIONADA: begin
            if (FILAS == 4'd0)
               estado_d = LIBERACION;
`ifdef TECLADO_REPETICION_EN
            else if (rep_q == RW'(REPETIR_CICLOS - 1))
               dig_stb_d = clase == CLASE_DIGITO;
            else
               rep_d = rep_q + 1'b1;
`endif
         end
         LIBERACION: begin
            if (!match)
               estado_d = PRESIONADA;
            else if (done)
               estado_d = ESCANEO;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         estado_q   <= ESCANEO;
         col_q      <= '0;
         fila_q     <= '0;
         div_q      <= '0;
         DIGITO     <= '0;
         DIGITO_STB <= 1'b0;
         BORRAR_STB <= 1'b0;
         ENTER_STB  <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         col_q      <= col_d;
         fila_q     <= fila_d;
         div_q      <= div_d;
         DIGITO     <= digito_d;
         DIGITO_STB <= dig_stb_d;
         BORRAR_STB <= borrar_stb_d;
         ENTER_STB  <= enter_stb_d;
      end
   end

endmodule
